// File: rtl/sdram_pkg.sv
// Shared SDRAM command encodings and init-sequencer state enum, used by the
// init sequencer, the main controller and the command-bus assertions.
package sdram_pkg;

  // {cs_n, ras_n, cas_n, we_n}
  typedef enum logic [3:0] {
    CMD_LMR     = 4'b0000,
    CMD_AR      = 4'b0001,
    CMD_PRE     = 4'b0010,
    CMD_NOP     = 4'b0111,
    CMD_INHIBIT = 4'b1111
  } cmd_t;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_PWRUP,
    ST_PRE,
    ST_WAIT_RP,
    ST_REF,
    ST_WAIT_RFC,
    ST_LMR,
    ST_WAIT_MRD,
    ST_DONE
  } init_state_t;

  localparam int PRE_ALL_BIT = 10;

endpackage

// File: rtl/sdram_init_timer.sv
// Loadable down-counter for init command spacing; holds at zero instead of wrapping.
module sdram_init_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/sdram_init_seq.sv
// SDRAM power-up sequencer: NOP window, PRECHARGE-ALL, N x AUTO-REFRESH, LOAD-MODE,
// then init_done. Outputs for a state are registered on the edge that enters it.
module sdram_init_seq
  import sdram_pkg::*;
#(
  parameter int PWRUP_CYCLES  = 10000,
  parameter int TRP_CYCLES    = 2,
  parameter int TRFC_CYCLES   = 7,
  parameter int TMRD_CYCLES   = 2,
  parameter int REFRESH_COUNT = 2,
  parameter int ADDR_W        = 13,
  parameter int BA_W          = 2,
  parameter logic [ADDR_W-1:0] MODE_REG = 13'h033
) (
  input  logic              sdram_clk,
  input  logic              sdram_rst,
  input  logic              sdram_en,
  output logic              sdram_cke,
  output logic              sdram_cs_n,
  output logic              sdram_ras_n,
  output logic              sdram_cas_n,
  output logic              sdram_we_n,
  output logic [BA_W-1:0]   sdram_ba,
  output logic [ADDR_W-1:0] sdram_addr,
  output logic              init_busy,
  output logic              init_done
);

  localparam int MAX_A = (PWRUP_CYCLES > TRP_CYCLES) ? PWRUP_CYCLES : TRP_CYCLES;
  localparam int MAX_B = (TRFC_CYCLES > TMRD_CYCLES) ? TRFC_CYCLES : TMRD_CYCLES;
  localparam int MAX_T = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int TW    = $clog2(MAX_T + 1);
  localparam int RW    = $clog2(REFRESH_COUNT + 1);

  // Wait states are entered one cycle after the command, hence the -2.
  localparam logic [TW-1:0] LD_PWRUP = TW'(PWRUP_CYCLES - 1);
  localparam logic [TW-1:0] LD_RP    = TW'((TRP_CYCLES  > 1) ? TRP_CYCLES  - 2 : 0);
  localparam logic [TW-1:0] LD_RFC   = TW'((TRFC_CYCLES > 1) ? TRFC_CYCLES - 2 : 0);
  localparam logic [TW-1:0] LD_MRD   = TW'((TMRD_CYCLES > 1) ? TMRD_CYCLES - 2 : 0);
  localparam logic [ADDR_W-1:0] PRE_ADDR = ADDR_W'(1) << PRE_ALL_BIT;

  init_state_t   state, next_state, after_ref;
  cmd_t          cmd_q;
  logic          en_q;
  logic [RW-1:0] ref_cnt;
  logic          tmr_load, tmr_zero;
  logic [TW-1:0] tmr_val;

  always_comb begin
    after_ref = (ref_cnt == RW'(REFRESH_COUNT)) ? ST_LMR : ST_REF;
    next_state = state;
    if (!sdram_en) begin
      next_state = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:     if (!en_q) next_state = ST_PWRUP;
        ST_PWRUP:    if (tmr_zero) next_state = ST_PRE;
        ST_PRE:      next_state = (TRP_CYCLES > 1) ? ST_WAIT_RP : ST_REF;
        ST_WAIT_RP:  if (tmr_zero) next_state = ST_REF;
        ST_REF:      next_state = (TRFC_CYCLES > 1) ? ST_WAIT_RFC : after_ref;
        ST_WAIT_RFC: if (tmr_zero) next_state = after_ref;
        ST_LMR:      next_state = (TMRD_CYCLES > 1) ? ST_WAIT_MRD : ST_DONE;
        ST_WAIT_MRD: if (tmr_zero) next_state = ST_DONE;
        ST_DONE:     next_state = ST_DONE;
        default:     next_state = ST_IDLE;
      endcase
    end
  end

  // Timer loads on every state entry; entering IDLE clears it.
  always_comb begin
    tmr_load = (next_state != state);
    tmr_val  = '0;
    case (next_state)
      ST_PWRUP:    tmr_val = LD_PWRUP;
      ST_WAIT_RP:  tmr_val = LD_RP;
      ST_WAIT_RFC: tmr_val = LD_RFC;
      ST_WAIT_MRD: tmr_val = LD_MRD;
      default:     tmr_val = '0;
    endcase
  end

  sdram_init_timer #(.W(TW)) u_timer (
    .clk      (sdram_clk),
    .rst      (sdram_rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  // en_q resets to 1 so an enable held high through reset is not seen as an edge.
  always_ff @(posedge sdram_clk) begin
    if (sdram_rst) begin
      state      <= ST_IDLE;
      en_q       <= 1'b1;
      ref_cnt    <= '0;
      cmd_q      <= CMD_INHIBIT;
      sdram_cke  <= 1'b0;
      sdram_ba   <= '0;
      sdram_addr <= '0;
      init_busy  <= 1'b0;
      init_done  <= 1'b0;
    end else begin
      state      <= next_state;
      en_q       <= sdram_en;
      sdram_ba   <= '0;
      sdram_addr <= '0;
      sdram_cke  <= (next_state != ST_IDLE);
      init_busy  <= (next_state != ST_IDLE) && (next_state != ST_DONE);
      init_done  <= (next_state == ST_DONE);
      if (next_state == ST_IDLE) ref_cnt <= '0;
      else if (next_state == ST_REF) ref_cnt <= ref_cnt + RW'(1);
      case (next_state)
        ST_IDLE: cmd_q <= CMD_INHIBIT;
        ST_PRE: begin
          cmd_q      <= CMD_PRE;
          sdram_addr <= PRE_ADDR;
        end
        ST_REF:  cmd_q <= CMD_AR;
        ST_LMR: begin
          cmd_q      <= CMD_LMR;
          sdram_addr <= MODE_REG;
        end
        default: cmd_q <= CMD_NOP;
      endcase
    end
  end

  assign {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = cmd_q;

endmodule

// File: tb/tb_sdram_init_seq.sv
// Directed bench for sdram_init_seq: default-parameter instance (a) and a short-timing
// instance (b), every output checked each cycle against a spec-derived schedule.
module tb_sdram_init_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b, en_a, en_b;
  logic a_cke, a_cs_n, a_ras_n, a_cas_n, a_we_n, a_busy, a_done;
  logic b_cke, b_cs_n, b_ras_n, b_cas_n, b_we_n, b_busy, b_done;
  logic [1:0]  a_ba, b_ba;
  logic [12:0] a_addr, b_addr;

  int n_checks = 0;
  int n_errors = 0;

  sdram_init_seq dut_a (
    .sdram_clk (clk), .sdram_rst (rst_a), .sdram_en (en_a),
    .sdram_cke (a_cke), .sdram_cs_n (a_cs_n), .sdram_ras_n (a_ras_n),
    .sdram_cas_n (a_cas_n), .sdram_we_n (a_we_n), .sdram_ba (a_ba),
    .sdram_addr (a_addr), .init_busy (a_busy), .init_done (a_done)
  );

  sdram_init_seq #(
    .PWRUP_CYCLES (4), .TRP_CYCLES (1), .TRFC_CYCLES (1),
    .TMRD_CYCLES (1), .REFRESH_COUNT (3)
  ) dut_b (
    .sdram_clk (clk), .sdram_rst (rst_b), .sdram_en (en_b),
    .sdram_cke (b_cke), .sdram_cs_n (b_cs_n), .sdram_ras_n (b_ras_n),
    .sdram_cas_n (b_cas_n), .sdram_we_n (b_we_n), .sdram_ba (b_ba),
    .sdram_addr (b_addr), .init_busy (b_busy), .init_done (b_done)
  );

  // Observed vector layout: {cmd[3:0], cke, busy, done, ba[1:0], addr[12:0]}
  function automatic logic [31:0] obs_a();
    return {10'd0, a_cs_n, a_ras_n, a_cas_n, a_we_n, a_cke, a_busy, a_done, a_ba, a_addr};
  endfunction

  function automatic logic [31:0] obs_b();
    return {10'd0, b_cs_n, b_ras_n, b_cas_n, b_we_n, b_cke, b_busy, b_done, b_ba, b_addr};
  endfunction

  // Expected outputs during cycle c (c = 0 is the edge cycle; c <= 0 means idle).
  function automatic logic [31:0] exp_vec(input int c, input int p, input int trp,
                                          input int trfc, input int tmrd, input int rc);
    logic [3:0]  cmd;
    logic [12:0] addr;
    logic        cke, busy, done;
    int          pre, lmr, fin;
    pre  = p + 1;
    lmr  = pre + trp + rc * trfc;
    fin  = lmr + tmrd;
    cmd  = 4'b1111;
    addr = 13'd0;
    cke  = 1'b0;
    busy = 1'b0;
    done = 1'b0;
    if (c >= 1) begin
      cke = 1'b1;
      cmd = 4'b0111;
      if (c >= fin) done = 1'b1;
      else busy = 1'b1;
      if (c == pre) begin
        cmd  = 4'b0010;
        addr = 13'h400;
      end else if (c == lmr) begin
        cmd  = 4'b0000;
        addr = 13'h033;
      end else if (c >= pre + trp && c < lmr && ((c - pre - trp) % trfc) == 0) begin
        cmd = 4'b0001;
      end
    end
    return {10'd0, cmd, cke, busy, done, 2'b00, addr};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic run_check(input string name, input bit sel, input int c0, input int c1,
                           input int p, input int trp, input int trfc, input int tmrd,
                           input int rc);
    for (int c = c0; c <= c1; c++) begin
      @(posedge clk);
      #1;
      check($sformatf("%s_c%0d", name, c), sel ? obs_b() : obs_a(),
            exp_vec(c, p, trp, trfc, tmrd, rc));
    end
  endtask

  task automatic run_idle(input string name, input bit sel, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("%s_%0d", name, i), sel ? obs_b() : obs_a(), exp_vec(0, 1, 1, 1, 1, 1));
    end
  endtask

  initial begin
    rst_a = 1'b1;
    rst_b = 1'b1;
    en_a  = 1'b0;
    en_b  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_a", obs_a(), exp_vec(0, 1, 1, 1, 1, 1));
    check("reset_b", obs_b(), exp_vec(0, 1, 1, 1, 1, 1));
    rst_a = 1'b0;
    rst_b = 1'b0;
    run_idle("pre_edge_a", 1'b0, 3);
    run_idle("pre_edge_b", 1'b1, 1);

    // Short timings: PRE 5, AR 6/7/8, LMR 9, done from 10.
    en_b = 1'b1;
    run_check("t5", 1'b1, 1, 14, 4, 1, 1, 1, 3);

    // Full default sequence.
    en_a = 1'b1;
    run_check("t1", 1'b0, 1, 10025, 10000, 2, 7, 2, 2);

    // Abort between the two refreshes, then restart at cycle 10020.
    en_a = 1'b0;
    run_idle("t3_off", 1'b0, 2);
    en_a = 1'b1;
    run_check("t3a", 1'b0, 1, 10005, 10000, 2, 7, 2, 2);
    en_a = 1'b0;
    run_idle("t3_drop", 1'b0, 15);
    en_a = 1'b1;
    run_check("t3b", 1'b0, 1, 10025, 10000, 2, 7, 2, 2);

    // Reset pulse during WAIT_RFC with enable held high.
    en_a = 1'b0;
    run_idle("t4_off", 1'b0, 2);
    en_a = 1'b1;
    run_check("t4a", 1'b0, 1, 10012, 10000, 2, 7, 2, 2);
    rst_a = 1'b1;
    @(posedge clk);
    #1;
    check("t4_rst", obs_a(), exp_vec(0, 1, 1, 1, 1, 1));
    rst_a = 1'b0;
    run_idle("t4_hold", 1'b0, 20);
    en_a = 1'b0;
    run_idle("t4_low", 1'b0, 1);
    en_a = 1'b1;
    run_check("t4b", 1'b0, 1, 5, 10000, 2, 7, 2, 2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
